// File: rtl/i2s_sample_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_sample_sequencer_pkg
// Brief    : Shared widths and sequencer state encoding for the audioport path
// Revision : 1.0
// ============================================================================
package i2s_sample_sequencer_pkg;

  localparam int AUDIO_W    = 24;
  localparam int UNDERRUN_W = 16;

  typedef enum logic [1:0] {
    STANDBY = 2'd0,
    PRIME   = 2'd1,
    PLAY    = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/i2s_sample_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_sample_sequencer_if
// Brief    : Sample-write handshake plus i2s_unit-facing signals of the sequencer
// Revision : 1.0
// ============================================================================
interface i2s_sample_sequencer_if;
  import i2s_sample_sequencer_pkg::*;

  logic               wr_valid_in;
  logic               wr_ready_out;
  logic [AUDIO_W-1:0] wr_left_in;
  logic [AUDIO_W-1:0] wr_right_in;
  logic               req_in;
  logic               play_out;
  logic               tick_out;
  logic [AUDIO_W-1:0] audio0_out;
  logic [AUDIO_W-1:0] audio1_out;

  // Sequencer side
  modport slave (
    input  wr_valid_in, wr_left_in, wr_right_in, req_in,
    output wr_ready_out, play_out, tick_out, audio0_out, audio1_out
  );

  // Sample source / i2s_unit side
  modport master (
    output wr_valid_in, wr_left_in, wr_right_in, req_in,
    input  wr_ready_out, play_out, tick_out, audio0_out, audio1_out
  );

endinterface
`default_nettype wire

// File: rtl/i2s_sample_sequencer_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sample_fifo
// Brief    : Stereo sample-pair FIFO with one-cycle flush and combinational head
// Revision : 1.0
// ============================================================================
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 48
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   push,
  input  wire logic                   pop,
  input  wire logic                   flush,
  input  wire logic [WIDTH-1:0]       data_in,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      level,
  output logic [WIDTH-1:0]            head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= data_in;
  end

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign level = r_wptr - r_rptr;
  assign head  = r_mem[r_rptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/i2s_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2s_sample_sequencer
// Brief    : Buffers sample pairs and serves i2s_unit requests with hold-timed play
// Revision : 1.0
// ============================================================================
module i2s_sample_sequencer
  import i2s_sample_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LEVEL = 4,
  parameter int MIN_HOLD    = 384
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        play_in,
  i2s_sample_sequencer_if.slave            bus,
  output logic [$clog2(FIFO_DEPTH):0]      level_out,
  output logic [UNDERRUN_W-1:0]            underrun_count_out
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam logic [HOLD_W-1:0]     c_min_hold    = HOLD_W'(MIN_HOLD);
  localparam logic [LVL_W-1:0]      c_prime_level = LVL_W'(PRIME_LEVEL);
  localparam logic [UNDERRUN_W-1:0] c_underrun_max = '1;

  seq_state_t             r_state;
  seq_state_t             w_state_next;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic                   w_hold_ok;
  logic                   w_flush;
  logic                   w_serve;
  logic                   w_clr_underrun;
  logic                   w_play_next;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [LVL_W-1:0]       w_level;
  logic [2*AUDIO_W-1:0]   w_head;
  logic                   r_play;
  logic                   r_tick;
  logic [AUDIO_W-1:0]     r_audio0;
  logic [AUDIO_W-1:0]     r_audio1;
  logic [UNDERRUN_W-1:0]  r_underrun;

  assign w_hold_ok = (r_hold_cnt == c_min_hold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= STANDBY;
    else        r_state <= w_state_next;
  end

  // A request arriving on the cycle play drops is deliberately not served.
  always_comb begin
    w_state_next   = r_state;
    w_flush        = 1'b0;
    w_serve        = 1'b0;
    w_clr_underrun = 1'b0;
    case (r_state)
      STANDBY: begin
        if (play_in && w_hold_ok) begin
          w_state_next   = PRIME;
          w_clr_underrun = 1'b1;
        end
      end
      PRIME: begin
        if (!play_in) begin
          w_state_next = STANDBY;
          w_flush      = 1'b1;
        end else if (w_level >= c_prime_level) begin
          w_state_next = PLAY;
        end
      end
      PLAY: begin
        if (!play_in && w_hold_ok) begin
          w_state_next = STANDBY;
          w_flush      = 1'b1;
        end else begin
          w_serve = bus.req_in;
        end
      end
      default: begin
        w_state_next = STANDBY;
        w_flush      = 1'b1;
      end
    endcase
    w_play_next = (w_state_next == PLAY);
  end

  assign bus.wr_ready_out = !w_full && !w_flush;
  assign w_push           = bus.wr_valid_in && bus.wr_ready_out;
  assign w_pop            = w_serve && !w_empty;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*AUDIO_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (w_flush),
    .data_in ({bus.wr_left_in, bus.wr_right_in}),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level),
    .head    (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_play     <= 1'b0;
      r_tick     <= 1'b0;
      r_audio0   <= '0;
      r_audio1   <= '0;
      r_underrun <= '0;
      r_hold_cnt <= c_min_hold;
    end else begin
      r_play <= w_play_next;
      r_tick <= w_serve;
      // Hold counter restarts on the cycle play_out changes.
      if (w_play_next != r_play)  r_hold_cnt <= '0;
      else if (!w_hold_ok)        r_hold_cnt <= r_hold_cnt + 1'b1;
      if (w_serve) begin
        if (w_empty) begin
          r_audio0 <= '0;
          r_audio1 <= '0;
          if (r_underrun != c_underrun_max) r_underrun <= r_underrun + 1'b1;
        end else begin
          r_audio0 <= w_head[2*AUDIO_W-1:AUDIO_W];
          r_audio1 <= w_head[AUDIO_W-1:0];
        end
      end else if (w_flush) begin
        r_audio0 <= '0;
        r_audio1 <= '0;
      end
      if (w_clr_underrun) r_underrun <= '0;
    end
  end

  assign bus.play_out       = r_play;
  assign bus.tick_out       = r_tick;
  assign bus.audio0_out     = r_audio0;
  assign bus.audio1_out     = r_audio1;
  assign level_out          = w_level;
  assign underrun_count_out = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_sample_sequencer
// Brief    : Directed bench with a tick-driven scoreboard for i2s_sample_sequencer
// Revision : 1.0
// ============================================================================
module tb_i2s_sample_sequencer;
  import i2s_sample_sequencer_pkg::*;

  typedef struct {
    logic [23:0] a0;
    logic [23:0] a1;
    logic [15:0] ucnt;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        play_in = 1'b0;
  logic [3:0]  level;
  logic [15:0] ucnt;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];
  exp_t mon_e;

  i2s_sample_sequencer_if bus();

  i2s_sample_sequencer #(
    .FIFO_DEPTH  (8),
    .PRIME_LEVEL (4),
    .MIN_HOLD    (384)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .play_in            (play_in),
    .bus                (bus),
    .level_out          (level),
    .underrun_count_out (ucnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
    bus.wr_valid_in = 1'b1;
    bus.wr_left_in  = l;
    bus.wr_right_in = r;
    step();
    bus.wr_valid_in = 1'b0;
  endtask

  task automatic do_req(input logic [23:0] a0, input logic [23:0] a1, input logic [15:0] u);
    exp_t e;
    e.a0 = a0; e.a1 = a1; e.ucnt = u;
    sb.push_back(e);
    bus.req_in = 1'b1;
    step();
    bus.req_in = 1'b0;
  endtask

  // Scoreboard monitor: every tick must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && bus.tick_out) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_tick: got tick with no expected entry (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("tick_audio0", {24'h0, bus.audio0_out}, {24'h0, mon_e.a0});
        chk("tick_audio1", {24'h0, bus.audio1_out}, {24'h0, mon_e.a1});
        chk("tick_underrun", {32'h0, ucnt}, {32'h0, mon_e.ucnt});
      end
    end
  end

  initial begin
    bus.wr_valid_in = 1'b0;
    bus.wr_left_in  = '0;
    bus.wr_right_in = '0;
    bus.req_in      = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_play",     {47'h0, bus.play_out}, 48'h0);
    chk("rst_tick",     {47'h0, bus.tick_out}, 48'h0);
    chk("rst_audio0",   {24'h0, bus.audio0_out}, 48'h0);
    chk("rst_audio1",   {24'h0, bus.audio1_out}, 48'h0);
    chk("rst_level",    {44'h0, level}, 48'h0);
    chk("rst_underrun", {32'h0, ucnt}, 48'h0);
    chk("rst_wr_ready", {47'h0, bus.wr_ready_out}, 48'h1);
    step();
    rst_n = 1'b1;

    // Prime with four pairs, then request play
    push_pair(24'h123456, 24'hABCDEF);
    push_pair(24'h111111, 24'h222222);
    push_pair(24'h333333, 24'h444444);
    push_pair(24'h555555, 24'h666666);
    chk("prime_level", {44'h0, level}, 48'd4);
    play_in = 1'b1;
    step();
    chk("prime_play_low", {47'h0, bus.play_out}, 48'h0);
    step();
    chk("play_rise", {47'h0, bus.play_out}, 48'h1);
    chk("play_audio0_idle", {24'h0, bus.audio0_out}, 48'h0);
    cyc = 0;

    // Serve the buffered pairs
    do_req(24'h123456, 24'hABCDEF, 16'd0);
    chk("pop_level", {44'h0, level}, 48'd3);
    chk("tick_high", {47'h0, bus.tick_out}, 48'h1);
    step();
    chk("tick_one_cycle", {47'h0, bus.tick_out}, 48'h0);
    do_req(24'h111111, 24'h222222, 16'd0);
    do_req(24'h333333, 24'h444444, 16'd0);
    do_req(24'h555555, 24'h666666, 16'd0);
    chk("drain_level", {44'h0, level}, 48'd0);

    // Underruns
    do_req(24'h0, 24'h0, 16'd1);
    do_req(24'h0, 24'h0, 16'd2);
    chk("underrun_count", {32'h0, ucnt}, 48'd2);

    // Drop play early; play_out must hold until the hold window expires
    while (cyc < 100) step();
    play_in = 1'b0;
    while (cyc < 200) step();
    push_pair(24'hAAAAAA, 24'hBBBBBB);
    push_pair(24'hCCCCCC, 24'hDDDDDD);
    while (cyc < 300) step();
    do_req(24'hAAAAAA, 24'hBBBBBB, 16'd2);
    chk("hold_serve_level", {44'h0, level}, 48'd1);
    while (cyc < 384) step();
    chk("hold_play_high", {47'h0, bus.play_out}, 48'h1);
    bus.req_in = 1'b1;
    step();
    bus.req_in = 1'b0;
    chk("hold_play_fall", {47'h0, bus.play_out}, 48'h0);
    chk("flush_level", {44'h0, level}, 48'd0);
    chk("flush_audio0", {24'h0, bus.audio0_out}, 48'h0);
    chk("fall_no_tick", {47'h0, bus.tick_out}, 48'h0);
    cyc = 0;

    // Fill to full in STANDBY, then replay after the hold window
    for (int i = 0; i < 8; i++) push_pair(24'h100000 + 24'(i), 24'h200000 + 24'(i));
    chk("full_level", {44'h0, level}, 48'd8);
    chk("full_wr_ready", {47'h0, bus.wr_ready_out}, 48'h0);
    play_in = 1'b1;
    while (!bus.play_out && cyc < 600) step();
    chk("replay_hold_cycles", 48'(cyc), 48'd386);
    chk("full_ready_play", {47'h0, bus.wr_ready_out}, 48'h0);
    bus.wr_valid_in = 1'b1;
    bus.wr_left_in  = 24'hEEEEEE;
    bus.wr_right_in = 24'hFFFFFF;
    do_req(24'h100000, 24'h200000, 16'd0);
    bus.wr_valid_in = 1'b0;
    chk("full_push_pop_level", {44'h0, level}, 48'd7);
    do_req(24'h100001, 24'h200001, 16'd0);
    do_req(24'h100002, 24'h200002, 16'd0);
    step();
    chk("pre_reset_level", {44'h0, level}, 48'd5);

    // Asynchronous reset in PLAY
    #2 rst_n = 1'b0;
    #1;
    chk("arst_play",   {47'h0, bus.play_out}, 48'h0);
    chk("arst_tick",   {47'h0, bus.tick_out}, 48'h0);
    chk("arst_audio0", {24'h0, bus.audio0_out}, 48'h0);
    chk("arst_audio1", {24'h0, bus.audio1_out}, 48'h0);
    chk("arst_level",  {44'h0, level}, 48'h0);
    play_in = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_play", {47'h0, bus.play_out}, 48'h0);
    chk("post_rst_ready", {47'h0, bus.wr_ready_out}, 48'h1);
    chk("scoreboard_empty", 48'(sb.size()), 48'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
